// File: rtl/memory_access.sv
// memory_access -- RV32I memory pipeline stage.
//
// Takes the execute-stage register outputs and either passes a non-memory
// result through in one cycle, or runs one load/store on a req/ack data bus.
// Loads are lane-selected and sign/zero extended; stores get byte enables and
// lane-replicated data. Execute is back-pressured through or_stall while the
// stage is busy or write-back is stalled.
//
// Ports
//   i_clk, i_rst                  clock, async active-high reset
//   i_opcode..i_pc                instruction fields from execute
//   i_flush                       kill the instruction in this stage
//   i_stall                       write-back cannot accept; hold outputs
//   or_dmem_* / i_dmem_*          data-memory request / response
//   or_opcode..or_pc              result to write-back
//   or_stall                      hold request to execute
//   or_misaligned                 pulse: misaligned access, no bus cycle
//   or_access_fault               pulse: bus ack carried err
module memory_access #(
  parameter int XLEN  = 32,
  parameter int XADDR = 5,
  parameter int OPLEN = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [OPLEN-1:0] i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_alu_result,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XADDR-1:0] i_rd_addr,
  input  logic             i_rd_wr_en,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_flush,
  input  logic             i_stall,
  output logic             or_dmem_req,
  output logic             or_dmem_we,
  output logic [XLEN-1:0]  or_dmem_addr,
  output logic [XLEN-1:0]  or_dmem_wdata,
  output logic [3:0]       or_dmem_be,
  input  logic             i_dmem_ack,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  input  logic             i_dmem_err,
  output logic [OPLEN-1:0] or_opcode,
  output logic [XADDR-1:0] or_rd_addr,
  output logic             or_rd_wr_en,
  output logic [XLEN-1:0]  or_rd_data,
  output logic [XLEN-1:0]  or_pc,
  output logic             or_stall,
  output logic             or_misaligned,
  output logic             or_access_fault
);

  localparam logic [OPLEN-1:0] L_OP = OPLEN'(7'b0000011);
  localparam logic [OPLEN-1:0] S_OP = OPLEN'(7'b0100011);

  typedef enum logic [1:0] {IDLE, BUS, HOLD} state_t;
  state_t state_q, state_d;

  // Decode of the incoming instruction (only consumed in IDLE).
  logic            is_load, is_store, is_mem, mis;
  logic [1:0]      off;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;

  // Instruction captured at bus issue; execute moves on once it is taken.
  logic [OPLEN-1:0] sv_opcode;
  logic [XADDR-1:0] sv_rd_addr;
  logic             sv_wr_en, sv_load, sv_kill;
  logic [2:0]       sv_f3;
  logic [1:0]       sv_off;
  logic [XLEN-1:0]  sv_alu, sv_pc;

  // Completed result parked while write-back is stalled.
  logic [XLEN-1:0] buf_data;
  logic            buf_wr_en, buf_err;

  logic [XLEN-1:0] lane, ld_data, res_data;
  logic            res_wr_en;

  always_comb begin
    is_load  = (i_opcode == L_OP);
    is_store = (i_opcode == S_OP);
    is_mem   = is_load | is_store;
    off      = i_alu_result[1:0];
    mis      = 1'b0;
    st_be    = 4'hF;
    st_wdata = i_rs2_data;
    case (i_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << off;
        st_wdata = {(XLEN/8){i_rs2_data[7:0]}};
      end
      2'b01: begin
        mis      = off[0];
        st_be    = 4'b0011 << {off[1], 1'b0};
        st_wdata = {(XLEN/16){i_rs2_data[15:0]}};
      end
      default: mis = (off != 2'b00);
    endcase
    mis = mis & is_mem;
  end

  // Load lane select and extension from the captured width/offset.
  always_comb begin
    lane = i_dmem_rdata >> {sv_off, 3'b000};
    case (sv_f3)
      3'b000:  ld_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: ld_data = lane;
    endcase
    // Stores report their effective address on rd_data; they never write rd.
    res_data  = sv_load ? ld_data : sv_alu;
    res_wr_en = sv_load & sv_wr_en & ~sv_kill & ~i_flush & ~i_dmem_err;
  end

  assign or_stall = (state_q != IDLE) | i_stall;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!i_stall && !i_flush && is_mem && !mis) state_d = BUS;
      BUS:     if (i_dmem_ack) state_d = i_stall ? HOLD : IDLE;
      HOLD:    if (!i_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      or_dmem_req     <= 1'b0;
      or_dmem_we      <= 1'b0;
      or_dmem_addr    <= '0;
      or_dmem_wdata   <= '0;
      or_dmem_be      <= '0;
      or_opcode       <= '0;
      or_rd_addr      <= '0;
      or_rd_wr_en     <= 1'b0;
      or_rd_data      <= '0;
      or_pc           <= '0;
      or_misaligned   <= 1'b0;
      or_access_fault <= 1'b0;
      sv_opcode       <= '0;
      sv_rd_addr      <= '0;
      sv_wr_en        <= 1'b0;
      sv_load         <= 1'b0;
      sv_kill         <= 1'b0;
      sv_f3           <= '0;
      sv_off          <= '0;
      sv_alu          <= '0;
      sv_pc           <= '0;
      buf_data        <= '0;
      buf_wr_en       <= 1'b0;
      buf_err         <= 1'b0;
    end else begin
      or_misaligned   <= 1'b0;
      or_access_fault <= 1'b0;
      case (state_q)
        IDLE: if (!i_stall) begin
          if (i_flush) begin
            or_opcode   <= '0;
            or_rd_wr_en <= 1'b0;
          end else if (!is_mem || mis) begin
            or_opcode     <= i_opcode;
            or_rd_addr    <= i_rd_addr;
            or_pc         <= i_pc;
            or_rd_data    <= i_alu_result;
            or_rd_wr_en   <= i_rd_wr_en & ~mis;
            or_misaligned <= mis;
          end else begin
            or_dmem_req   <= 1'b1;
            or_dmem_we    <= is_store;
            or_dmem_addr  <= {i_alu_result[XLEN-1:2], 2'b00};
            or_dmem_be    <= is_store ? st_be : 4'b0000;
            or_dmem_wdata <= st_wdata;
            or_rd_wr_en   <= 1'b0;
            sv_opcode     <= i_opcode;
            sv_rd_addr    <= i_rd_addr;
            sv_wr_en      <= i_rd_wr_en;
            sv_load       <= is_load;
            sv_kill       <= 1'b0;
            sv_f3         <= i_funct3;
            sv_off        <= off;
            sv_alu        <= i_alu_result;
            sv_pc         <= i_pc;
          end
        end
        BUS: begin
          if (i_flush) sv_kill <= 1'b1;
          if (i_dmem_ack) begin
            or_dmem_req <= 1'b0;
            if (!i_stall) begin
              or_opcode       <= sv_opcode;
              or_rd_addr      <= sv_rd_addr;
              or_pc           <= sv_pc;
              or_rd_data      <= res_data;
              or_rd_wr_en     <= res_wr_en;
              or_access_fault <= i_dmem_err;
            end else begin
              buf_data  <= res_data;
              buf_wr_en <= res_wr_en;
              buf_err   <= i_dmem_err;
            end
          end
        end
        HOLD: begin
          if (i_flush) buf_wr_en <= 1'b0;
          if (!i_stall) begin
            or_opcode       <= sv_opcode;
            or_rd_addr      <= sv_rd_addr;
            or_pc           <= sv_pc;
            or_rd_data      <= buf_data;
            or_rd_wr_en     <= buf_wr_en & ~i_flush;
            or_access_fault <= buf_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  localparam logic [6:0] OP_L = 7'h03, OP_S = 7'h23, OP_ADDI = 7'h13, OP_ADD = 7'h33;

  logic        i_clk, i_rst;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [31:0] i_alu_result, i_rs2_data, i_pc;
  logic [4:0]  i_rd_addr;
  logic        i_rd_wr_en, i_flush, i_stall;
  logic        or_dmem_req, or_dmem_we;
  logic [31:0] or_dmem_addr, or_dmem_wdata;
  logic [3:0]  or_dmem_be;
  logic        i_dmem_ack, i_dmem_err;
  logic [31:0] i_dmem_rdata;
  logic [6:0]  or_opcode;
  logic [4:0]  or_rd_addr;
  logic        or_rd_wr_en;
  logic [31:0] or_rd_data, or_pc;
  logic        or_stall, or_misaligned, or_access_fault;

  memory_access dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
    .i_rd_wr_en(i_rd_wr_en), .i_pc(i_pc), .i_flush(i_flush), .i_stall(i_stall),
    .or_dmem_req(or_dmem_req), .or_dmem_we(or_dmem_we), .or_dmem_addr(or_dmem_addr),
    .or_dmem_wdata(or_dmem_wdata), .or_dmem_be(or_dmem_be), .i_dmem_ack(i_dmem_ack),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_err(i_dmem_err), .or_opcode(or_opcode),
    .or_rd_addr(or_rd_addr), .or_rd_wr_en(or_rd_wr_en), .or_rd_data(or_rd_data),
    .or_pc(or_pc), .or_stall(or_stall), .or_misaligned(or_misaligned),
    .or_access_fault(or_access_fault)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: what the stage must produce for one instruction.
  typedef struct {
    logic        mem, ld, st, mis;
    logic [3:0]  be;
    logic [31:0] wdata, rdv;
  } mdl_t;

  function automatic mdl_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [31:0] rdat);
    mdl_t m;
    int size, off;
    logic [31:0] v, mask;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(a % 4);
    m.ld  = (op == OP_L);
    m.st  = (op == OP_S);
    m.mem = m.ld | m.st;
    m.mis = m.mem && (off % size != 0);
    m.be  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (m.st && i >= off && i < off + size) m.be[i] = 1'b1;
      m.wdata[8*i +: 8] = rs2[8*(i % size) +: 8];
    end
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
    v = (rdat >> (8*off)) & mask;
    if (size < 4 && !f3[2] && v[8*size-1]) v = v | ~mask;
    m.rdv = v;
    return m;
  endfunction

  // Expected DUT outputs, maintained by the stimulus tasks.
  logic        chk_on = 1'b0;
  logic        exp_req, exp_we, exp_wr, exp_stall, exp_mis, exp_fault;
  logic [31:0] exp_addr, exp_wdata, exp_data, exp_pc;
  logic [3:0]  exp_be;
  logic [6:0]  exp_op;
  logic [4:0]  exp_rd;

  always @(negedge i_clk) if (chk_on) begin
    chk("req", 32'(or_dmem_req), 32'(exp_req));
    if (exp_req) begin
      chk("addr", or_dmem_addr, exp_addr);
      chk("we", 32'(or_dmem_we), 32'(exp_we));
      chk("be", 32'(or_dmem_be), 32'(exp_be));
      if (exp_we) chk("wdata", or_dmem_wdata, exp_wdata);
    end
    chk("rd_wr_en", 32'(or_rd_wr_en), 32'(exp_wr));
    chk("rd_data", or_rd_data, exp_data);
    chk("opcode", 32'(or_opcode), 32'(exp_op));
    chk("rd_addr", 32'(or_rd_addr), 32'(exp_rd));
    chk("pc", or_pc, exp_pc);
    chk("stall", 32'(or_stall), 32'(exp_stall));
    chk("misaligned", 32'(or_misaligned), 32'(exp_mis));
    chk("fault", 32'(or_access_fault), 32'(exp_fault));
  end

  task automatic tick();
    @(posedge i_clk); #1;
    exp_mis = 1'b0;
    exp_fault = 1'b0;
  endtask

  task automatic drive_nop();
    i_opcode = '0; i_funct3 = '0; i_alu_result = '0; i_rs2_data = '0;
    i_rd_addr = '0; i_rd_wr_en = 1'b0; i_pc = '0; i_flush = 1'b0;
  endtask

  task automatic exp_zero();
    exp_req = 0; exp_we = 0; exp_wr = 0; exp_stall = 0; exp_mis = 0; exp_fault = 0;
    exp_addr = 0; exp_wdata = 0; exp_data = 0; exp_pc = 0; exp_be = 0; exp_op = 0; exp_rd = 0;
  endtask

  task automatic idle(input int n);
    drive_nop();
    for (int i = 0; i < n; i++) begin
      tick();
      exp_op = 0; exp_rd = 0; exp_pc = 0; exp_data = 0; exp_wr = 0; exp_stall = 0;
    end
  endtask

  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic we,
                        input logic [31:0] pc, input int waits, input logic [31:0] rdat,
                        input logic err, input int hold, input logic flush_bus);
    mdl_t m;
    m = model(op, f3, a, rs2, rdat);
    i_opcode = op; i_funct3 = f3; i_alu_result = a; i_rs2_data = rs2;
    i_rd_addr = rd; i_rd_wr_en = we; i_pc = pc; i_flush = 0; i_stall = 0;
    exp_stall = 0;
    tick();
    drive_nop();
    if (!m.mem || m.mis) begin
      exp_op = op; exp_rd = rd; exp_pc = pc; exp_data = a;
      exp_wr = we & ~m.mis; exp_mis = m.mis; exp_req = 0;
      return;
    end
    exp_req = 1; exp_we = m.st; exp_addr = a & ~32'd3; exp_be = m.be;
    exp_wdata = m.wdata; exp_wr = 0; exp_stall = 1;
    for (int i = 0; i < waits; i++) begin
      i_flush = flush_bus && (i == 0);
      tick();
      i_flush = 0;
    end
    i_dmem_ack = 1; i_dmem_rdata = rdat; i_dmem_err = err; i_stall = (hold > 0);
    tick();
    i_dmem_ack = 0; i_dmem_rdata = 32'h5A5A_A5A5; i_dmem_err = 0;
    exp_req = 0;
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) tick();
      i_stall = 0;
      tick();
    end
    exp_op = op; exp_rd = rd; exp_pc = pc;
    exp_data = m.ld ? m.rdv : a;
    exp_wr = m.ld & we & ~err & ~flush_bus;
    exp_fault = err;
    exp_stall = 0;
  endtask

  initial begin
    mdl_t m;
    i_rst = 1; i_stall = 0; i_dmem_ack = 0; i_dmem_rdata = 0; i_dmem_err = 0;
    drive_nop();
    exp_zero();

    // Pin the model against hand-computed values.
    m = model(OP_L, 3'b000, 32'h103, 0, 32'h80FF_0000);
    chk("m_lb", m.rdv, 32'hFFFF_FF80);
    m = model(OP_S, 3'b001, 32'h202, 32'hABCD_1234, 0);
    chk("m_sh_be", 32'(m.be), 32'hC);
    chk("m_sh_wdata", m.wdata, 32'h1234_1234);
    m = model(OP_L, 3'b101, 32'h2, 0, 32'h8001_0000);
    chk("m_lhu", m.rdv, 32'h0000_8001);
    m = model(OP_L, 3'b010, 32'h101, 0, 0);
    chk("m_lw_mis", 32'(m.mis), 32'd1);

    chk_on = 1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    idle(1);

    run_op(OP_ADDI, 3'b000, 32'h1234, 0, 5'd5, 1, 32'h1000, 0, 0, 0, 0, 0);
    chk("addi_data", or_rd_data, 32'h1234);
    run_op(OP_L, 3'b000, 32'h103, 0, 5'd6, 1, 32'h1004, 2, 32'h80FF_0000, 0, 0, 0);
    chk("lb_data", or_rd_data, 32'hFFFF_FF80);
    run_op(OP_S, 3'b001, 32'h202, 32'hABCD_1234, 5'd0, 0, 32'h1008, 0, 0, 0, 0, 0);
    run_op(OP_L, 3'b010, 32'h101, 0, 5'd7, 1, 32'h100C, 0, 0, 0, 0, 0);
    chk("lw_mis_pulse", 32'(or_misaligned), 32'd1);
    run_op(OP_L, 3'b101, 32'h2, 0, 5'd8, 1, 32'h1010, 0, 32'h8001_0000, 0, 3, 0);
    chk("lhu_data", or_rd_data, 32'h0000_8001);
    run_op(OP_S, 3'b000, 32'h11, 32'h0000_005A, 5'd0, 0, 32'h1014, 1, 0, 0, 0, 0);
    run_op(OP_L, 3'b001, 32'h6, 0, 5'd9, 1, 32'h1018, 0, 32'h8001_7FFF, 0, 0, 0);
    run_op(OP_L, 3'b010, 32'h8, 0, 5'd10, 1, 32'h101C, 1, 32'hDEAD_BEEF, 0, 0, 0);
    run_op(OP_L, 3'b100, 32'h101, 0, 5'd11, 1, 32'h1020, 0, 32'h0000_C300, 0, 0, 0);
    chk("lbu_data", or_rd_data, 32'h0000_00C3);
    run_op(OP_S, 3'b010, 32'h20, 32'hCAFE_BABE, 5'd0, 0, 32'h1024, 0, 0, 0, 0, 0);
    run_op(OP_S, 3'b001, 32'h3, 32'h1111_2222, 5'd0, 0, 32'h1028, 0, 0, 0, 0, 0);
    run_op(OP_L, 3'b010, 32'h300, 0, 5'd12, 1, 32'h102C, 0, 32'h1122_3344, 1, 0, 0);
    chk("err_fault", 32'(or_access_fault), 32'd1);
    run_op(OP_L, 3'b010, 32'h44, 0, 5'd13, 1, 32'h1030, 2, 32'h0000_0055, 0, 0, 1);
    chk("flush_bus_wr", 32'(or_rd_wr_en), 32'd0);
    run_op(OP_ADD, 3'b000, 32'h77, 0, 5'd14, 1, 32'h1034, 0, 0, 0, 0, 0);

    // Flush in IDLE: bubble, nothing issued even for a memory op.
    i_opcode = OP_L; i_funct3 = 3'b010; i_alu_result = 32'h80; i_rd_addr = 5'd15;
    i_rd_wr_en = 1; i_pc = 32'h1038; i_flush = 1;
    tick();
    exp_op = 0; exp_wr = 0;
    drive_nop();

    // Write-back stall while idle: outputs frozen, instruction held back.
    run_op(OP_ADDI, 3'b000, 32'h99, 0, 5'd16, 1, 32'h103C, 0, 0, 0, 0, 0);
    i_opcode = OP_ADDI; i_alu_result = 32'hAA; i_rd_addr = 5'd17; i_rd_wr_en = 1;
    i_pc = 32'h1040; i_stall = 1; exp_stall = 1;
    repeat (2) tick();
    chk("stall_hold", or_rd_data, 32'h99);
    run_op(OP_ADDI, 3'b000, 32'hAA, 0, 5'd17, 1, 32'h1040, 0, 0, 0, 0, 0);

    // Reset mid-transaction drops req at once; a late ack changes nothing.
    i_opcode = OP_L; i_funct3 = 3'b010; i_alu_result = 32'h40; i_rd_addr = 5'd18;
    i_rd_wr_en = 1; i_pc = 32'h1044;
    tick();
    drive_nop();
    exp_req = 1; exp_we = 0; exp_addr = 32'h40; exp_be = 0; exp_wr = 0; exp_stall = 1;
    tick();
    i_rst = 1;
    exp_zero();
    #1 chk("rst_req", 32'(or_dmem_req), 32'd0);
    @(posedge i_clk); #1 i_rst = 0;
    i_dmem_ack = 1; i_dmem_rdata = 32'h1234_5678;
    tick();
    i_dmem_ack = 0;
    chk("late_ack_req", 32'(or_dmem_req), 32'd0);
    chk("late_ack_wr", 32'(or_rd_wr_en), 32'd0);
    idle(2);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
